riscv_mc_ctrl: RTL and testbench

//  Multi-cycle control sequencer for the RV32 core datapath (regfile + alu32).

---
 rtl/riscv_mc_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle control sequencer for the RV32 datapath.
// Runs one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. Supports
// R, I(ALU), S, B, LUI and JAL. Any other opcode, a fetch timeout or a
// misaligned control-flow target halts the core in TRAP until reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_*                   fetch handshake (req held until valid)
//   rf_ra1/ra2, rf_read1/2   regfile read addresses / combinational data
//   rf_we/wa/wdata           regfile write port
//   alu_ctrl/a/b, alu_r      ALU operands, {funct7,funct3} and result
//   alu_branch               branch condition from the ALU
//   dmem_*                   store handshake (req held until ready)
//   retire                   1-cycle pulse per completed instruction
//   trap, mcause, mepc       sticky halt flag, cause code, faulting PC
module riscv_mc_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_read1,
  input  logic [31:0] rf_read2,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wdata,
  output logic [9:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_r,
  input  logic        alu_branch,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  output logic        retire,
  output logic        trap,
  output logic [3:0]  mcause,
  output logic [31:0] mepc
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_S = 7'h23,
                         OP_B = 7'h63, OP_U = 7'h37, OP_J = 7'h6F;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, ir_q, ir_d;
  logic [31:0]   rs1v_q, rs1v_d, rs2v_q, rs2v_d, res_q, res_d;
  logic [31:0]   mepc_q, mepc_d;
  logic [3:0]    mcause_q, mcause_d;
  logic [CW-1:0] wait_q, wait_d;

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, pc_plus4, br_tgt;

  assign opcode   = ir_q[6:0];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_u    = {ir_q[31:12], 12'b0};
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_q + imm_b;

  assign rf_ra1 = ir_q[19:15];
  assign rf_ra2 = ir_q[24:20];
  assign trap   = (state_q == S_TRAP);
  assign mcause = mcause_q;
  assign mepc   = mepc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rs1v_d     = rs1v_q;
    rs2v_d     = rs2v_q;
    res_d      = res_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    wait_d     = wait_q;
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    rf_we      = 1'b0;
    rf_wa      = ir_q[11:7];
    rf_wdata   = res_q;
    alu_ctrl   = 10'd0;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    dmem_req   = 1'b0;
    dmem_addr  = res_q;
    dmem_wdata = rs2v_q;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == CW'(FETCH_TIMEOUT - 1)) begin
          // this is the FETCH_TIMEOUT-th cycle without a response
          state_d  = S_TRAP;
          mcause_d = 4'd1;
          mepc_d   = pc_q;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        rs1v_d = rf_read1;
        rs2v_d = rf_read2;
        case (opcode)
          OP_R, OP_I, OP_S, OP_B, OP_U, OP_J: state_d = S_EXEC;
          default: begin
            state_d  = S_TRAP;
            mcause_d = 4'd2;
            mepc_d   = pc_q;
          end
        endcase
      end
      S_EXEC: begin
        res_d   = alu_r;
        state_d = S_WB;
        case (opcode)
          OP_R: begin
            alu_a = rs1v_q; alu_b = rs2v_q; alu_ctrl = {ir_q[31:25], ir_q[14:12]};
          end
          OP_I: begin
            alu_a = rs1v_q; alu_b = imm_i; alu_ctrl = {7'b0, ir_q[14:12]};
          end
          OP_S: begin
            alu_a = rs1v_q; alu_b = imm_s;
            state_d = S_MEM;
          end
          OP_B: begin
            alu_a = rs1v_q; alu_b = rs2v_q; alu_ctrl = {7'b0, ir_q[14:12]};
            if (alu_branch && br_tgt[1:0] != 2'b00) begin
              state_d  = S_TRAP;
              mcause_d = 4'd0;
              mepc_d   = pc_q;
            end else begin
              pc_d    = alu_branch ? br_tgt : pc_plus4;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_U: begin
            alu_b = imm_u;
          end
          OP_J: begin
            alu_a = pc_q; alu_b = imm_j;
            // the ALU sum is the jump target that WB loads into pc
            if (alu_r[1:0] != 2'b00) begin
              state_d  = S_TRAP;
              mcause_d = 4'd0;
              mepc_d   = pc_q;
            end
          end
          default: begin
            state_d  = S_TRAP;
            mcause_d = 4'd2;
            mepc_d   = pc_q;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          pc_d    = pc_plus4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rf_we    = (ir_q[11:7] != 5'd0);
        rf_wdata = (opcode == OP_J) ? pc_plus4 : res_q;
        pc_d     = (opcode == OP_J) ? res_q : pc_plus4;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      rs1v_q   <= '0;
      rs2v_q   <= '0;
      res_q    <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      rs1v_q   <= rs1v_d;
      rs2v_q   <= rs2v_d;
      res_q    <= res_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      wait_q   <= wait_d;
    end
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl. Plays imem/regfile/ALU/dmem by hand and
// checks sequencing, handshakes, PC flow and the three trap causes.
module tb_riscv_mc_ctrl;

  logic        clk = 1'b0, rst;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [31:0] rf_read1, rf_read2, rf_wdata;
  logic        rf_we;
  logic [9:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_r;
  logic        alu_branch;
  logic        dmem_req, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        retire, trap;
  logic [3:0]  mcause;
  logic [31:0] mepc;

  int n_vec = 0, n_err = 0;

  riscv_mc_ctrl #(.RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_read1(rf_read1), .rf_read2(rf_read2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_branch(alu_branch),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .retire(retire), .trap(trap), .mcause(mcause), .mepc(mepc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point sits 2 time units after the rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b0; dmem_ready = 1'b0; alu_branch = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
  endtask

  // single-instruction run through FETCH/DECODE/EXEC/WB, starting in FETCH
  task automatic run_wb(input string t, input logic [31:0] instr, r1, r2, ar, ea, eb,
                        input logic [9:0] ec, input logic ewe, input logic [4:0] ewa,
                        input logic [31:0] ewd, enpc);
    rf_read1 = r1; rf_read2 = r2; alu_r = ar;
    imem_rdata = instr; imem_valid = 1'b1;
    cyc(); imem_valid = 1'b0; #1;
    chk({t, ".dec_req"}, imem_req, 0);
    chk({t, ".ra1"}, rf_ra1, instr[19:15]);
    chk({t, ".ra2"}, rf_ra2, instr[24:20]);
    cyc();
    chk({t, ".alu_a"}, alu_a, ea);
    chk({t, ".alu_b"}, alu_b, eb);
    chk({t, ".alu_ctrl"}, alu_ctrl, ec);
    cyc();
    chk({t, ".we"}, rf_we, ewe);
    chk({t, ".wa"}, rf_wa, ewa);
    chk({t, ".wdata"}, rf_wdata, ewd);
    chk({t, ".wb_retire"}, retire, 1);
    chk({t, ".wb_req"}, {imem_req, dmem_req}, 0);
    cyc();
    chk({t, ".next_req"}, imem_req, 1);
    chk({t, ".next_addr"}, imem_addr, enpc);
    chk({t, ".retire_off"}, retire, 0);
    chk({t, ".we_off"}, rf_we, 0);
  endtask

  // branch: FETCH/DECODE/EXEC, back to FETCH
  task automatic run_br(input string t, input logic [31:0] instr, input logic taken,
                        input logic [31:0] enpc);
    rf_read1 = 32'h3; rf_read2 = 32'h3; alu_r = 32'h0;
    imem_rdata = instr; imem_valid = 1'b1;
    cyc(); imem_valid = 1'b0;
    cyc(); alu_branch = taken; #1;
    chk({t, ".ctrl"}, alu_ctrl, 10'h000);
    chk({t, ".retire"}, retire, 1);
    cyc(); alu_branch = 1'b0; #1;
    chk({t, ".req"}, imem_req, 1);
    chk({t, ".addr"}, imem_addr, enpc);
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; rf_read1 = '0; rf_read2 = '0;
    alu_r = '0; alu_branch = 1'b0; dmem_ready = 1'b0;

    // reset state
    do_reset();
    chk("rst.imem_req", imem_req, 1);
    chk("rst.imem_addr", imem_addr, 0);
    chk("rst.rf_we", rf_we, 0);
    chk("rst.trap", trap, 0);
    chk("rst.dmem_req", dmem_req, 0);
    chk("rst.mcause", mcause, 0);
    chk("rst.mepc", mepc, 0);

    // add x3,x1,x2 at pc 0
    run_wb("add", 32'h002081B3, 5, 7, 12, 5, 7, 10'h000, 1'b1, 5'd3, 12, 32'h4);

    // sw x2,8(x1) at pc 4, ready after 3 wait cycles
    rf_read1 = 32'h100; rf_read2 = 32'hDEADBEEF; alu_r = 32'h108;
    imem_rdata = 32'h0020A423; imem_valid = 1'b1;
    cyc(); imem_valid = 1'b0;
    cyc(); #1;
    chk("sw.alu_a", alu_a, 32'h100);
    chk("sw.alu_b", alu_b, 32'h8);
    chk("sw.alu_ctrl", alu_ctrl, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); #1;
      chk("sw.dmem_req", dmem_req, 1);
      chk("sw.dmem_addr", dmem_addr, 32'h108);
      chk("sw.dmem_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("sw.rf_we", rf_we, 0);
      chk("sw.imem_req", imem_req, 0);
      chk("sw.retire", retire, (i == 3));
      cyc();
    end
    dmem_ready = 1'b0; #1;
    chk("sw.dmem_off", dmem_req, 0);
    chk("sw.next_addr", imem_addr, 32'h8);

    // nop (rd=0 suppresses write), then addi x5,x1,-1
    run_wb("nop", 32'h00000013, 0, 0, 0, 0, 0, 10'h000, 1'b0, 5'd0, 0, 32'hC);
    run_wb("addi", 32'hFFF08293, 10, 0, 9, 10, 32'hFFFFFFFF, 10'h000, 1'b1, 5'd5, 9, 32'h10);

    // beq +8 at 0x10 not taken, beq -4 at 0x14 taken, beq +8 at 0x10 taken
    run_br("beq_nt", 32'h00208463, 1'b0, 32'h14);
    run_br("beq_back", 32'hFE208EE3, 1'b1, 32'h10);
    run_br("beq_tk", 32'h00208463, 1'b1, 32'h18);

    // jal x1,+8 at 0x18; lui x7 at 0x20; sub x4,x1,x2 at 0x24
    run_wb("jal", 32'h008000EF, 0, 0, 32'h20, 32'h18, 32'h8, 10'h000, 1'b1, 5'd1, 32'h1C, 32'h20);
    run_wb("lui", 32'h123453B7, 32'h55, 32'h66, 32'h12345000, 0, 32'h12345000, 10'h000,
           1'b1, 5'd7, 32'h12345000, 32'h24);
    run_wb("sub", 32'h40208233, 9, 4, 5, 9, 4, 10'h100, 1'b1, 5'd4, 5, 32'h28);

    // beq +2 taken at 0x28: misaligned target traps
    imem_rdata = 32'h00208163; imem_valid = 1'b1;
    cyc(); imem_valid = 1'b0;
    cyc(); alu_branch = 1'b1; #1;
    chk("mis.retire", retire, 0);
    cyc(); alu_branch = 1'b0; #1;
    chk("mis.trap", trap, 1);
    chk("mis.mcause", mcause, 0);
    chk("mis.mepc", mepc, 32'h28);
    chk("mis.imem_req", imem_req, 0);

    // illegal opcode at pc 4
    do_reset();
    chk("rst2.trap", trap, 0);
    run_wb("nop2", 32'h00000013, 0, 0, 0, 0, 0, 10'h000, 1'b0, 5'd0, 0, 32'h4);
    imem_rdata = 32'h0000007F; imem_valid = 1'b1;
    cyc(); imem_valid = 1'b0;
    cyc(); #1;
    chk("ill.trap", trap, 1);
    chk("ill.mcause", mcause, 2);
    chk("ill.mepc", mepc, 32'h4);
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ill.imem_req", imem_req, 0);
      chk("ill.side", {rf_we, dmem_req, retire}, 0);
      cyc();
    end
    imem_valid = 1'b0;
    chk("ill.trap_sticky", trap, 1);

    // fetch timeout: 16 FETCH cycles, then trap; late valid ignored
    do_reset();
    chk("rst3.trap", trap, 0);
    chk("rst3.mcause", mcause, 0);
    for (int i = 0; i < 16; i++) begin
      chk("to.imem_req", imem_req, 1);
      chk("to.no_trap", trap, 0);
      cyc();
    end
    chk("to.trap", trap, 1);
    chk("to.mcause", mcause, 1);
    chk("to.mepc", mepc, 0);
    chk("to.imem_req_off", imem_req, 0);
    imem_rdata = 32'h002081B3; imem_valid = 1'b1;
    cyc(); cyc(); imem_valid = 1'b0; #1;
    chk("to.late_trap", trap, 1);
    chk("to.late_req", imem_req, 0);
    chk("to.late_side", {rf_we, dmem_req, retire}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
